// File: rtl/card_dealer.sv
// card_dealer
// ---------------------------------------------------------------------------
// Purpose:
//   This block deals cards to CHANNELS independent hands. All hands share one
//   free-running card counter, cnt, which steps MIN_VAL..MAX_VAL and wraps.
//   When draw[k] rises, channel k is dealt a card. The card value is cnt
//   offset by k, taken modulo the card range. Because of the offset, hands
//   that draw in the same cycle always receive different values.
//   Each hand keeps:
//     - its last card,
//     - a running total,
//     - a card count,
//     - a sticky bust flag that is set once the total exceeds LIMIT.
//   A hand accepts no more cards after it busts or after it holds MAX_CARDS
//   cards.
//
// Optional feature (macro CARD_DEALER_SOFT_ACE_EN):
//   A card of value 1 counts as 11 when the hand can take 11 without passing
//   LIMIT. Such a hand is marked "soft". A later card that would push a soft
//   hand past LIMIT demotes the ace back to 1 (subtract 10). With the macro
//   undefined, every card counts at face value and no soft state exists.
//   The card output always shows the face value.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   enable      in   1 = card counter advances each clock, 0 = counter holds
//   draw        in   [CHANNELS]          per-channel draw level; a rising edge deals
//   clear       in   [CHANNELS]          per-channel synchronous hand clear
//   card        out  [CHANNELS*WIDTH]    last card per channel, ch k at [k*WIDTH +: WIDTH]
//   card_valid  out  [CHANNELS]          one-cycle pulse per dealt card
//   total       out  [CHANNELS*TOTAL_W]  hand total per channel
//   count       out  [CHANNELS*4]        cards in hand per channel
//   bust        out  [CHANNELS]          high while the hand total exceeds LIMIT
//
// Handshake:
//   There is no ready/valid back-pressure. A draw is a level input; its
//   rising edge is the request. card_valid is a one-cycle strobe, and it is
//   qualified by the same edge that updates card, total and count.
//   card, total and count then remain stable until the next deal or clear.
// ---------------------------------------------------------------------------
module card_dealer #(
   parameter int CHANNELS  = 2,
   parameter int WIDTH     = 5,
   parameter int MIN_VAL   = 1,
   parameter int MAX_VAL   = 10,
   parameter int TOTAL_W   = 6,
   parameter int LIMIT     = 21,
   parameter int MAX_CARDS = 11
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [CHANNELS-1:0]          draw,
   input  logic [CHANNELS-1:0]          clear,
   output logic [CHANNELS*WIDTH-1:0]    card,
   output logic [CHANNELS-1:0]          card_valid,
   output logic [CHANNELS*TOTAL_W-1:0]  total,
   output logic [CHANNELS*4-1:0]        count,
   output logic [CHANNELS-1:0]          bust
);

   localparam int                 RANGE       = MAX_VAL - MIN_VAL + 1;
   localparam logic [WIDTH-1:0]   MIN_V       = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]   MAX_V       = WIDTH'(MAX_VAL);
   localparam logic [TOTAL_W-1:0] LIMIT_T     = TOTAL_W'(LIMIT);
   localparam logic [3:0]         MAX_CARDS_C = 4'(MAX_CARDS);

   // ------------------------------------------------------------------
   // Shared card counter
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
         cnt_d = (cnt_q == MAX_V) ? MIN_V : cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Registered copy of draw, used for rising-edge detection.
   // It resets to all ones, so a draw that is held high while reset is
   // released does not look like a fresh rising edge.
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0] draw_prev_q, draw_prev_d;

   assign draw_prev_d = draw;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q       <= MIN_V;
         draw_prev_q <= '1;
      end else begin
         cnt_q       <= cnt_d;
         draw_prev_q <= draw_prev_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-channel hand state
   // ------------------------------------------------------------------
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0]   val;
      logic               draw_evt;
      logic [TOTAL_W-1:0] add_val;
      logic [TOTAL_W-1:0] sum;

      logic [WIDTH-1:0]   card_q,  card_d;
      logic               valid_q, valid_d;
      logic [TOTAL_W-1:0] total_q, total_d;
      logic [3:0]         count_q, count_d;
      logic               bust_q,  bust_d;
`ifdef CARD_DEALER_SOFT_ACE_EN
      logic               soft_q,  soft_d;
`endif

      // Channel k sees the shared counter rotated by k within the card range.
      assign val      = WIDTH'(MIN_VAL + ((int'(cnt_q) - MIN_VAL + k) % RANGE));
      assign draw_evt = draw[k] & ~draw_prev_q[k];

      always_comb begin
         card_d  = card_q;
         valid_d = 1'b0;
         total_d = total_q;
         count_d = count_q;
         bust_d  = bust_q;
         add_val = TOTAL_W'(val);
         sum     = total_q;
`ifdef CARD_DEALER_SOFT_ACE_EN
         soft_d  = soft_q;
`endif
         if (clear[k]) begin
            // A clear wins over a draw in the same cycle; that draw edge is
            // dropped, because draw_prev still records it as seen.
            card_d  = '0;
            total_d = '0;
            count_d = '0;
            bust_d  = 1'b0;
`ifdef CARD_DEALER_SOFT_ACE_EN
            soft_d  = 1'b0;
`endif
         end else if (draw_evt && !bust_q && (count_q != MAX_CARDS_C)) begin
            card_d  = val;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
`ifdef CARD_DEALER_SOFT_ACE_EN
            if ((val == WIDTH'(1)) && (int'(total_q) + 11 <= LIMIT)) begin
               add_val = TOTAL_W'(11);
               soft_d  = 1'b1;
            end
            sum = total_q + add_val;
            // Demote a soft ace before the bust flag is evaluated.
            if (soft_q && (sum > LIMIT_T)) begin
               sum    = sum - TOTAL_W'(10);
               soft_d = 1'b0;
            end
`else
            sum = total_q + add_val;
`endif
            total_d = sum;
            bust_d  = (sum > LIMIT_T);
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            card_q  <= '0;
            valid_q <= 1'b0;
            total_q <= '0;
            count_q <= '0;
            bust_q  <= 1'b0;
`ifdef CARD_DEALER_SOFT_ACE_EN
            soft_q  <= 1'b0;
`endif
         end else begin
            card_q  <= card_d;
            valid_q <= valid_d;
            total_q <= total_d;
            count_q <= count_d;
            bust_q  <= bust_d;
`ifdef CARD_DEALER_SOFT_ACE_EN
            soft_q  <= soft_d;
`endif
         end
      end

      assign card[k*WIDTH +: WIDTH]     = card_q;
      assign card_valid[k]              = valid_q;
      assign total[k*TOTAL_W +: TOTAL_W] = total_q;
      assign count[k*4 +: 4]            = count_q;
      assign bust[k]                    = bust_q;
   end

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer in its default 2-channel configuration.
// A hand-level reference model tracks the counter, the face values and the
// ace count of each hand. A compare process checks every output on each
// falling clock edge. Directed scenarios add literal expectations at known
// points in the run.
module tb_card_dealer;

   localparam int CH   = 2;
   localparam int W    = 5;
   localparam int MINV = 1;
   localparam int MAXV = 10;
   localparam int TW   = 6;
   localparam int LIM  = 21;
   localparam int MAXC = 11;

   logic              clock  = 1'b0;
   logic              reset  = 1'b0;
   logic              enable = 1'b0;
   logic [CH-1:0]     draw   = '0;
   logic [CH-1:0]     clear  = '0;
   logic [CH*W-1:0]   card;
   logic [CH-1:0]     card_valid;
   logic [CH*TW-1:0]  total;
   logic [CH*4-1:0]   count;
   logic [CH-1:0]     bust;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   card_dealer dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .draw       (draw),
      .clear      (clear),
      .card       (card),
      .card_valid (card_valid),
      .total      (total),
      .count      (count),
      .bust       (bust)
   );

   // ---------------- clock ----------------
   initial forever #5 clock = ~clock;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int d_card(input int k);
      return int'(card[k*W +: W]);
   endfunction
   function automatic int d_total(input int k);
      return int'(total[k*TW +: TW]);
   endfunction
   function automatic int d_count(input int k);
      return int'(count[k*4 +: 4]);
   endfunction

   // ---------------- reference model ----------------
   // A hand is summarised by the sum of its face values and the number of
   // aces in it. With soft aces enabled, the hand value is the best total:
   // one ace is counted as 11 whenever that still fits under the limit.
   int            m_cnt;
   int            m_card  [CH];
   int            m_sum   [CH];
   int            m_aces  [CH];
   int            m_count [CH];
   bit            m_valid [CH];
   bit            m_bust  [CH];
   logic [CH-1:0] m_prev;
   int            m_v;

   function automatic int m_total(input int k);
`ifdef CARD_DEALER_SOFT_ACE_EN
      if (m_aces[k] > 0 && m_sum[k] + 10 <= LIM) return m_sum[k] + 10;
`endif
      return m_sum[k];
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_cnt  = MINV;
         m_prev = '1;
         for (int k = 0; k < CH; k++) begin
            m_card[k] = 0; m_sum[k] = 0; m_aces[k] = 0;
            m_count[k] = 0; m_valid[k] = 1'b0; m_bust[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            m_valid[k] = 1'b0;
            if (clear[k]) begin
               m_card[k] = 0; m_sum[k] = 0; m_aces[k] = 0;
               m_count[k] = 0; m_bust[k] = 1'b0;
            end else if (draw[k] && !m_prev[k] && !m_bust[k] && m_count[k] < MAXC) begin
               m_v = MINV + ((m_cnt - MINV + k) % (MAXV - MINV + 1));
               m_card[k]  = m_v;
               m_valid[k] = 1'b1;
               m_count[k] = m_count[k] + 1;
               m_sum[k]   = m_sum[k] + m_v;
               if (m_v == 1) m_aces[k] = m_aces[k] + 1;
               m_bust[k]  = (m_total(k) > LIM);
            end
         end
         m_prev = draw;
         if (enable) m_cnt = (m_cnt == MAXV) ? MINV : m_cnt + 1;
      end
   end

   // ---------------- per-cycle scoreboard ----------------
   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < CH; k++) begin
            check($sformatf("card[%0d]", k),       d_card(k),             m_card[k]);
            check($sformatf("card_valid[%0d]", k), int'(card_valid[k]),   int'(m_valid[k]));
            check($sformatf("total[%0d]", k),      d_total(k),            m_total(k));
            check($sformatf("count[%0d]", k),      d_count(k),            m_count[k]);
            check($sformatf("bust[%0d]", k),       int'(bust[k]),         int'(m_bust[k]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change only on falling edges, so they are settled at each
   // rising edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at a falling edge; returns at a falling edge with reset released.
   task automatic do_reset(input logic [CH-1:0] draw_during);
      #2;
      reset  = 1'b1;
      draw   = draw_during;
      clear  = '0;
      enable = 1'b0;
      cyc(2);
      reset  = 1'b0;
   endtask

   // Raise draw for one edge, then drop it again.
   task automatic deal(input logic [CH-1:0] m);
      draw = m;
      cyc(1);
   endtask

   task automatic undeal();
      draw = '0;
      cyc(1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      #2;
      reset  = 1'b1;
      chk_en = 1'b1;
      cyc(1);
      check("reset_total0", d_total(0), 0);
      check("reset_count0", d_count(0), 0);
      check("reset_card1",  d_card(1),  0);
      check("reset_bust",   int'(bust), 0);
      reset = 1'b0;

      // First card after 12 enabled clocks: the counter wraps 1..10, so it reads 3.
      enable = 1'b1;
      cyc(12);
      deal(2'b01);
      check("first_card0",  d_card(0),            3);
      check("first_valid0", int'(card_valid[0]),  1);
      check("first_total0", d_total(0),           3);
      check("first_count0", d_count(0),           1);
      undeal();
      check("first_pulse_end", int'(card_valid[0]), 0);

      // Simultaneous draws with cnt=10: the channel offset wraps to 1.
      do_reset('0);
      enable = 1'b1;
      cyc(9);
      enable = 1'b0;
      deal(2'b11);
      check("simul_card0",  d_card(0),  10);
      check("simul_card1",  d_card(1),  1);
      check("simul_valid",  int'(card_valid), 3);
      check("simul_total0", d_total(0), 10);
      check("simul_total1", d_total(1), 1);
      undeal();

      // Channel 0 draws 10, 10, 5 and busts; a fourth draw is ignored.
      deal(2'b01);
      undeal();
      enable = 1'b1;
      cyc(5);
      enable = 1'b0;
      deal(2'b01);
      check("bust_card0",  d_card(0),     5);
      check("bust_total0", d_total(0),    25);
      check("bust_flag0",  int'(bust[0]), 1);
      undeal();
      deal(2'b01);
      check("bust_nopulse", int'(card_valid[0]), 0);
      check("bust_count0",  d_count(0),          3);
      undeal();

      // Clear together with a draw edge: the clear wins and the edge is consumed.
      clear = 2'b01;
      deal(2'b01);
      clear = 2'b00;
      check("clr_total0", d_total(0),          0);
      check("clr_count0", d_count(0),          0);
      check("clr_bust0",  int'(bust[0]),      0);
      check("clr_valid0", int'(card_valid[0]), 0);
      check("clr_keep1",  d_total(1),          1);
      cyc(2);
      check("clr_held_count0", d_count(0), 0);
      undeal();
      deal(2'b01);
      check("clr_redraw_valid0", int'(card_valid[0]), 1);
      check("clr_redraw_total0", d_total(0),          5);
      undeal();

      // A hand is capped at 11 cards (eleven 1s, cnt held at 1).
      do_reset('0);
      cyc(1);
      for (int i = 0; i < MAXC; i++) begin
         deal(2'b01);
         undeal();
      end
      check("cap_count0", d_count(0), 11);
`ifdef CARD_DEALER_SOFT_ACE_EN
      check("cap_total0", d_total(0), 21);
`else
      check("cap_total0", d_total(0), 11);
`endif
      deal(2'b01);
      check("cap_nopulse", int'(card_valid[0]), 0);
      undeal();

      // Cards 1, 9, 5.
      do_reset('0);
      cyc(1);
      deal(2'b01);
`ifdef CARD_DEALER_SOFT_ACE_EN
      check("ace_total_a", d_total(0), 11);
`else
      check("ace_total_a", d_total(0), 1);
`endif
      undeal();
      enable = 1'b1;
      cyc(8);
      enable = 1'b0;
      deal(2'b01);
`ifdef CARD_DEALER_SOFT_ACE_EN
      check("ace_total_b", d_total(0), 20);
`else
      check("ace_total_b", d_total(0), 10);
`endif
      undeal();
      enable = 1'b1;
      cyc(6);
      enable = 1'b0;
      deal(2'b01);
      check("ace_card_c",  d_card(0),     5);
      check("ace_total_c", d_total(0),    15);
      check("ace_bust_c",  int'(bust[0]), 0);
      undeal();

      // draw[1] held high across reset release must not deal.
      do_reset(2'b10);
      cyc(3);
      check("hold_count1", d_count(1), 0);
      draw = '0;
      // Build a hand of 10 + 7, then assert reset mid-hand.
      enable = 1'b1;
      cyc(9);
      enable = 1'b0;
      deal(2'b01);
      undeal();
      enable = 1'b1;
      cyc(7);
      enable = 1'b0;
      deal(2'b01);
      check("mid_total0", d_total(0), 17);
      draw = '0;
      #2;
      reset = 1'b1;
      #1;
      check("async_total0", d_total(0),       0);
      check("async_count0", d_count(0),       0);
      check("async_card0",  d_card(0),        0);
      check("async_valid",  int'(card_valid), 0);
      cyc(1);
      reset = 1'b0;
      cyc(1);

      // Mixed traffic, checked against the model.
      for (int i = 0; i < 300; i++) begin
         enable = 1'($urandom_range(0, 1));
         draw   = 2'($urandom_range(0, 3));
         clear  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cyc(1);
      end
      draw  = '0;
      clear = '0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent hands (1..8).
REQ-002 SHALL have parameter WIDTH, default 5: card value width.
REQ-003 SHALL have parameter MIN_VAL, default 1, and MAX_VAL, default 10: inclusive card range, MIN_VAL < MAX_VAL < 2^WIDTH.
REQ-004 SHALL have parameter TOTAL_W, default 6, LIMIT, default 21, and MAX_CARDS, default 11: total width, bust threshold, cards-per-hand cap.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: enable  in  1  high = card counter advances each clock.
REQ-008 SHALL have ports: draw  in  CHANNELS  per-channel draw request, level, rising edge acts.
REQ-009 SHALL have ports: clear  in  CHANNELS  per-channel synchronous hand clear.
REQ-010 SHALL have ports: card  out  CHANNELS*WIDTH  last card dealt per channel, channel k at [k*WIDTH +: WIDTH].
REQ-011 SHALL have ports: card_valid  out  CHANNELS  one-cycle pulse per dealt card.
REQ-012 SHALL have ports: total  out  CHANNELS*TOTAL_W  hand sum per channel.
REQ-013 SHALL have ports: count  out  CHANNELS*4  cards in hand per channel.
REQ-014 SHALL have ports: bust  out  CHANNELS  high while total > LIMIT.

Function
REQ-015 SHALL keep one shared counter cnt: MIN_VAL..MAX_VAL, +1 per clock when enable=1, MAX_VAL wraps to MIN_VAL, held when enable=0.
REQ-016 SHALL register draw into draw_d each clock; draw event for k = draw[k] & ~draw_d[k].
REQ-017 SHALL, on a draw event for k at edge N, load card[k] with channel value v_k = MIN_VAL + ((cnt - MIN_VAL + k) mod (MAX_VAL-MIN_VAL+1)), using cnt as sampled at edge N.
REQ-018 SHALL, at the same edge, pulse card_valid[k] high for exactly one cycle, add the card's value to total[k], and increment count[k]; latency one clock from the first sample of draw high.
REQ-019 SHALL give simultaneous draw events on different channels distinct values (offset k) in the same cycle, all serviced.
REQ-020 SHALL ignore a draw event (no pulse, no change) when bust[k]=1 or count[k]=MAX_CARDS.
REQ-021 SHALL set bust[k] on the edge where the updated total exceeds LIMIT; bust stays high until clear or reset.
REQ-022 SHALL, on clear[k]=1 at an edge, zero card[k], total[k], count[k], bust[k], card_valid[k]; clear wins over a simultaneous draw event, and that draw event is consumed.
REQ-023 SHALL serve draw events while enable=0, using the held cnt.
REQ-024 SHALL hold totals without wrap: largest reachable total is LIMIT + MAX_VAL, which must fit in TOTAL_W.

Reset
REQ-025 SHALL on reset=1 set immediately: cnt=MIN_VAL, card=0, card_valid=0, total=0, count=0, bust=0, and soft flags=0.
REQ-026 SHALL reset draw_d to all ones so a draw held high through reset release gives no draw event.
REQ-027 SHALL abort any in-progress update on reset mid-operation; the first draw after release follows REQ-016..018.

Configuration
REQ-028 SHALL, when CARD_DEALER_SOFT_ACE_EN is defined, add a card of value 1 as 11 if total+11 <= LIMIT, and set per-channel soft[k].
REQ-029 SHALL, with CARD_DEALER_SOFT_ACE_EN, subtract 10 and clear soft[k] in the same edge when an addition would exceed LIMIT while soft[k]=1; bust is evaluated after the adjustment.
REQ-030 SHALL, without CARD_DEALER_SOFT_ACE_EN, add every card at its face value, with no soft state; card output always shows the face value.

Verification
REQ-031 Reset, enable=1, 12 clocks, draw[0] rising -> card[0]=3 (cnt 1..10 wrap), card_valid[0] one cycle, total[0]=3, count[0]=1.
REQ-032 With cnt=10, draw=2'b11 same cycle -> card[0]=10, card[1]=1, both valid pulses, totals 10 and 1.
REQ-033 Channel 0 draws 10,10,5 -> after third card total=25, bust[0]=1; a fourth draw gives no pulse and count stays 3.
REQ-034 clear[0] and a draw event same cycle -> total[0]=0, count[0]=0, bust[0]=0, card_valid[0]=0; draw held high afterwards yields nothing until it falls and rises again.
REQ-035 draw[1] held high across reset deassertion -> no card_valid[1]; reset asserted mid-hand with total=17 -> all outputs 0 asynchronously.
REQ-036 With CARD_DEALER_SOFT_ACE_EN: cards 1 then 9 -> total 20; then 5 -> total 15, bust=0. Without the macro: same cards -> totals 1, 10, 15.
